axi4_lite_regfile: RTL and testbench
====================================

AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: byte-address width of AWADDR/ARADDR.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, 32 or 64 only.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of DATA_WIDTH-bit registers, 1 to 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-high. Ports: ACLK input 1 (clock); ARESET input 1 (synchronous active-high reset).
REQ-005 SHALL have ports S_AWADDR input ADDR_WIDTH; S_AWVALID input 1; S_AWREADY output 1.
REQ-006 SHALL have ports S_WDATA input DATA_WIDTH; S_WSTRB input DATA_WIDTH/8; S_WVALID input 1; S_WREADY output 1.
REQ-007 SHALL have ports S_BRESP output 2; S_BVALID output 1; S_BREADY input 1.
REQ-008 SHALL have ports S_ARADDR input ADDR_WIDTH; S_ARVALID input 1; S_ARREADY output 1.
REQ-009 SHALL have ports S_RDATA output DATA_WIDTH; S_RRESP output 2; S_RVALID output 1; S_RREADY input 1.

Function
REQ-010 Register index SHALL be addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low address bits are ignored. Index >= NUM_REGS is out-of-range.
REQ-011 Write FSM SHALL have states W_IDLE, W_RESP. AW and W channels are accepted independently.
REQ-012 In W_IDLE, S_AWREADY SHALL be 1 until an AW handshake occurs. The address is then held and S_AWREADY is 0 until the next return to W_IDLE. S_WREADY SHALL behave the same for the W channel.
REQ-013 Write SHALL commit on the rising edge where both address and data are held or are handshaking in that cycle (AW and W may be simultaneous or in either order). FSM enters W_RESP and S_BVALID=1 the next cycle.
REQ-014 Commit SHALL update only the byte lanes whose S_WSTRB bit is 1. WSTRB=0 is a legal write that leaves the register unchanged and responds OKAY.
REQ-015 In W_RESP, S_BVALID and S_BRESP SHALL hold stable until S_BREADY=1. Then the FSM returns to W_IDLE and both readies are 1 the following cycle.
REQ-016 Read FSM SHALL have states R_IDLE, R_DATA and run independently of the write FSM.
REQ-017 In R_IDLE, S_ARREADY=1. On AR handshake, S_RDATA/S_RRESP are registered and S_RVALID=1 the next cycle (1-cycle latency). S_ARREADY=0 while in R_DATA.
REQ-018 S_RDATA/S_RRESP SHALL hold stable while S_RVALID=1 and S_RREADY=0. The R handshake returns the FSM to R_IDLE.
REQ-019 On a same-edge write commit and AR handshake to one register, read SHALL return the pre-write value.
REQ-020 OKAY SHALL be 2'b00 and SLVERR 2'b10. In-range accesses always return OKAY.
REQ-021 When S_RVALID=0, S_RDATA SHALL be 0.

Reset
REQ-022 While ARESET=1 at a rising edge, all registers SHALL clear to 0. S_AWREADY, S_WREADY, S_ARREADY, S_BVALID and S_RVALID SHALL be 0. S_BRESP, S_RRESP and S_RDATA SHALL be 0. Both FSMs return to idle.
REQ-023 Readies SHALL rise in the first cycle after ARESET deasserts.
REQ-024 Reset mid-transaction SHALL discard held AW/W/AR state and pending responses, with no partial write.

Configuration
REQ-025 Macro AXIL_SLVERR_EN defined: out-of-range write is dropped and S_BRESP=SLVERR; out-of-range read returns S_RDATA=0 and S_RRESP=SLVERR.
REQ-026 Macro AXIL_SLVERR_EN undefined: out-of-range write is dropped and responds OKAY; out-of-range read returns 0 and responds OKAY. Handshake timing is identical in both builds.

Verification (defaults: DATA_WIDTH=32, NUM_REGS=16)
REQ-027 Simultaneous AW=0x08, W=0xDEADBEEF, WSTRB=0xF, BREADY=1 -> BVALID one cycle later, BRESP=00; then read 0x08 -> RDATA=0xDEADBEEF one cycle after AR handshake.
REQ-028 W (0x11223344) issued 3 cycles before AW=0x0C -> WREADY low after W handshake; commit on AW handshake; reg3=0x11223344.
REQ-029 reg2=0xAABBCCDD; write 0x08 data 0x00000011, WSTRB=0x1 -> reg2 reads 0xAABBCC11.
REQ-030 RREADY held 0 for 5 cycles after read of 0x04 -> RVALID/RDATA stable for all 5 cycles; ARREADY=0 throughout.
REQ-031 Write 0x40 (index 16) and read 0x40 -> with AXIL_SLVERR_EN: BRESP=10, RRESP=10, RDATA=0, no register changed; without it: both responses 00.
REQ-032 ARESET pulsed while BVALID=1 after writing reg1 -> BVALID=0 and reg1 reads 0 after reset; readies are 1 on the first post-reset cycle.

Source files
------------

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: AXI4-Lite slave exposing NUM_REGS byte-strobed DATA_WIDTH-bit registers.
// Ports: ACLK/ARESET (sync active-high); AW, W and B write channels; AR and R read channels (S_ prefix).
// Macro AXIL_SLVERR_EN: out-of-range accesses respond SLVERR (2'b10) instead of OKAY; timing is unchanged.
module axi4_lite_regfile #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic live, aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0] w_strb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic aw_hs, w_hs, ar_hs, commit, w_in, r_in;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd, rd_val;
  logic [NB-1:0] ws;
  logic [ADDR_WIDTH-LSB-1:0] widx, ridx;
  // live holds the readies low until the first edge after reset is released
  assign S_AWREADY = live && w_state == W_IDLE && !aw_held;
  assign S_WREADY = live && w_state == W_IDLE && !w_held;
  assign S_ARREADY = live && r_state == R_IDLE;
  assign S_BVALID = w_state == W_RESP;
  assign S_RVALID = r_state == R_DATA;
  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs = S_WVALID && S_WREADY;
  assign ar_hs = S_ARVALID && S_ARREADY;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign wa = aw_held ? aw_addr_q : S_AWADDR;
  assign wd = w_held ? w_data_q : S_WDATA;
  assign ws = w_held ? w_strb_q : S_WSTRB;
  assign widx = wa[ADDR_WIDTH-1:LSB];
  assign ridx = S_ARADDR[ADDR_WIDTH-1:LSB];
  assign w_in = 32'(widx) < NUM_REGS;
  assign r_in = 32'(ridx) < NUM_REGS;
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) if (32'(ridx) == i) rd_val = regs[i];
  end
  always_comb begin
    w_next = w_state == W_IDLE ? (commit ? W_RESP : W_IDLE) : (S_BREADY ? W_IDLE : W_RESP);
    r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (S_RREADY ? R_IDLE : R_DATA);
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      live <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      S_BRESP <= OKAY;
      S_RRESP <= OKAY;
      S_RDATA <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      live <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        S_BRESP <= w_in ? OKAY : ERR;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_addr_q <= S_AWADDR;
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data_q <= S_WDATA;
          w_strb_q <= S_WSTRB;
        end
      end
      // out-of-range indices match no register, so such writes are dropped
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < NB; b++)
          if (commit && 32'(widx) == i && ws[b]) regs[i][b*8+:8] <= wd[b*8+:8];
      // rd_val samples regs before this edge's commit lands
      if (ar_hs) begin
        S_RDATA <= rd_val;
        S_RRESP <= r_in ? OKAY : ERR;
      end else if (S_RVALID && S_RREADY) S_RDATA <= '0;
    end
  end
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// tb_axi4_lite_regfile: directed self-checking bench with a register-array model of the regfile.
module tb_axi4_lite_regfile;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [7:0] S_AWADDR = '0, S_ARADDR = '0;
  logic [31:0] S_WDATA = '0, S_RDATA;
  logic [3:0] S_WSTRB = '0;
  logic S_AWVALID = 0, S_WVALID = 0, S_BREADY = 0, S_ARVALID = 0, S_RREADY = 0;
  logic S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
  logic [1:0] S_BRESP, S_RRESP;
  axi4_lite_regfile dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );
  always #5 ACLK = ~ACLK;
  int errors = 0, checks = 0;
  bit mon = 0;
  logic [31:0] model [16];
  logic [31:0] exp_rdata = '0, got;
  logic [1:0] exp_rresp = '0, exp_bresp = '0, bresp;
  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, g, e);
    end
  endtask
  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask
  always @(negedge ACLK) if (mon) begin
    if (S_RVALID) begin
      chk("rdata", S_RDATA, exp_rdata);
      chk("rresp", S_RRESP, exp_rresp);
      chk("arready_busy", S_ARREADY, 0);
    end else chk("rdata_idle", S_RDATA, 0);
    if (S_BVALID) begin
      chk("bresp", S_BRESP, exp_bresp);
      chk("awready_busy", S_AWREADY, 0);
      chk("wready_busy", S_WREADY, 0);
    end
  end
  function automatic int idx_of(input logic [7:0] a);
    return int'(a >> 2);
  endfunction
  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    k = idx_of(a);
    exp_bresp = k < 16 ? 2'b00 : ERR;
    if (k < 16) for (int b = 0; b < 4; b++) if (s[b]) model[k][b*8+:8] = d[b*8+:8];
  endtask
  task automatic set_read_exp(input logic [7:0] a);
    int k;
    k = idx_of(a);
    exp_rdata = k < 16 ? model[k] : 32'h0;
    exp_rresp = k < 16 ? 2'b00 : ERR;
  endtask
  task automatic reset_seq;
    ARESET = 1;
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0; S_BREADY = 0; S_RREADY = 0;
    tick;
    @(negedge ACLK);
    chk("rst_awready", S_AWREADY, 0);
    chk("rst_wready", S_WREADY, 0);
    chk("rst_arready", S_ARREADY, 0);
    chk("rst_bvalid", S_BVALID, 0);
    chk("rst_rvalid", S_RVALID, 0);
    chk("rst_bresp", S_BRESP, 0);
    chk("rst_rresp", S_RRESP, 0);
    chk("rst_rdata", S_RDATA, 0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    ARESET = 0;
    tick;
    @(negedge ACLK);
    chk("post_rst_awready", S_AWREADY, 1);
    chk("post_rst_wready", S_WREADY, 1);
    chk("post_rst_arready", S_ARREADY, 1);
    tick;
  endtask
  task automatic write_sim(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
    S_AWVALID = 1; S_WVALID = 1; S_BREADY = 1;
    @(negedge ACLK);
    chk("w_awready", S_AWREADY, 1);
    chk("w_wready", S_WREADY, 1);
    chk("w_bvalid_early", S_BVALID, 0);
    model_write(a, d, s);
    tick;
    S_AWVALID = 0; S_WVALID = 0;
    @(negedge ACLK);
    chk("w_bvalid", S_BVALID, 1);
    r = S_BRESP;
    tick;
    @(negedge ACLK);
    chk("w_bvalid_done", S_BVALID, 0);
    chk("w_awready_back", S_AWREADY, 1);
    chk("w_wready_back", S_WREADY, 1);
    tick;
  endtask
  task automatic read(input logic [7:0] a, input int hold, output logic [31:0] g);
    S_ARADDR = a; S_ARVALID = 1; S_RREADY = 0;
    set_read_exp(a);
    @(negedge ACLK);
    chk("r_arready", S_ARREADY, 1);
    chk("r_rvalid_early", S_RVALID, 0);
    tick;
    S_ARVALID = 0;
    @(negedge ACLK);
    chk("r_rvalid", S_RVALID, 1);
    g = S_RDATA;
    for (int i = 0; i < hold; i++) begin
      tick;
      @(negedge ACLK);
      chk("r_rvalid_hold", S_RVALID, 1);
    end
    S_RREADY = 1;
    tick;
    S_RREADY = 0;
    @(negedge ACLK);
    chk("r_rvalid_done", S_RVALID, 0);
    chk("r_arready_back", S_ARREADY, 1);
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) tick;
    reset_seq;
    mon = 1;
    write_sim(8'h08, 32'hDEADBEEF, 4'hF, bresp);
    chk("req027_bresp", bresp, 2'b00);
    read(8'h08, 0, got);
    chk("req027_rdata", got, 32'hDEADBEEF);
    // W three cycles ahead of AW
    S_WDATA = 32'h11223344; S_WSTRB = 4'hF; S_WVALID = 1; S_BREADY = 1;
    tick;
    S_WVALID = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("req028_wready_low", S_WREADY, 0);
      chk("req028_awready_high", S_AWREADY, 1);
      chk("req028_no_bvalid", S_BVALID, 0);
      tick;
    end
    S_AWADDR = 8'h0C; S_AWVALID = 1;
    model_write(8'h0C, 32'h11223344, 4'hF);
    tick;
    S_AWVALID = 0;
    @(negedge ACLK);
    chk("req028_bvalid", S_BVALID, 1);
    tick;
    tick;
    read(8'h0C, 0, got);
    chk("req028_rdata", got, 32'h11223344);
    // AW ahead of W
    S_AWADDR = 8'h20; S_AWVALID = 1; S_BREADY = 1;
    tick;
    S_AWVALID = 0;
    @(negedge ACLK);
    chk("aw_first_awready_low", S_AWREADY, 0);
    chk("aw_first_no_bvalid", S_BVALID, 0);
    tick;
    S_WDATA = 32'h0BADCAFE; S_WSTRB = 4'hF; S_WVALID = 1;
    model_write(8'h20, 32'h0BADCAFE, 4'hF);
    tick;
    S_WVALID = 0;
    @(negedge ACLK);
    chk("aw_first_bvalid", S_BVALID, 1);
    tick;
    tick;
    read(8'h20, 0, got);
    chk("aw_first_rdata", got, 32'h0BADCAFE);
    write_sim(8'h08, 32'hAABBCCDD, 4'hF, bresp);
    write_sim(8'h08, 32'h00000011, 4'h1, bresp);
    read(8'h08, 0, got);
    chk("req029_rdata", got, 32'hAABBCC11);
    write_sim(8'h08, 32'hFFFFFFFF, 4'h0, bresp);
    chk("wstrb0_bresp", bresp, 2'b00);
    read(8'h08, 0, got);
    chk("wstrb0_rdata", got, 32'hAABBCC11);
    write_sim(8'h04, 32'h12345678, 4'hF, bresp);
    read(8'h04, 5, got);
    chk("req030_rdata", got, 32'h12345678);
    write_sim(8'h40, 32'hCAFEF00D, 4'hF, bresp);
    chk("req031_bresp", bresp, ERR);
    read(8'h40, 0, got);
    chk("req031_rdata", got, 32'h0);
    chk("req031_rresp", S_RRESP, ERR);
    read(8'h00, 0, got);
    chk("req031_reg0_untouched", got, 32'h0);
    write_sim(8'h3C, 32'h5A5A0F0F, 4'hF, bresp);
    chk("last_reg_bresp", bresp, 2'b00);
    read(8'h3C, 0, got);
    chk("last_reg_rdata", got, 32'h5A5A0F0F);
    write_sim(8'h1B, 32'h600DF00D, 4'hF, bresp);
    read(8'h18, 0, got);
    chk("low_bits_ignored", got, 32'h600DF00D);
    // same-edge write commit and read of one register
    write_sim(8'h14, 32'h00000055, 4'hF, bresp);
    set_read_exp(8'h14);
    S_AWADDR = 8'h14; S_WDATA = 32'h00000099; S_WSTRB = 4'hF;
    S_ARADDR = 8'h14; S_AWVALID = 1; S_WVALID = 1; S_ARVALID = 1; S_BREADY = 1; S_RREADY = 0;
    @(negedge ACLK);
    chk("req019_arready", S_ARREADY, 1);
    model_write(8'h14, 32'h00000099, 4'hF);
    tick;
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0;
    @(negedge ACLK);
    chk("req019_bvalid", S_BVALID, 1);
    chk("req019_rdata", S_RDATA, 32'h00000055);
    S_RREADY = 1;
    tick;
    S_RREADY = 0;
    tick;
    read(8'h14, 0, got);
    chk("req019_after", got, 32'h00000099);
    // reset while a write response is pending
    S_AWADDR = 8'h04; S_WDATA = 32'h77777777; S_WSTRB = 4'hF;
    S_AWVALID = 1; S_WVALID = 1; S_BREADY = 0;
    model_write(8'h04, 32'h77777777, 4'hF);
    tick;
    S_AWVALID = 0; S_WVALID = 0;
    repeat (3) begin
      @(negedge ACLK);
      chk("req032_bvalid_held", S_BVALID, 1);
      tick;
    end
    reset_seq;
    @(negedge ACLK);
    chk("req032_bvalid_cleared", S_BVALID, 0);
    tick;
    read(8'h04, 0, got);
    chk("req032_reg1", got, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
